// File: rtl/stoch_to_bin.sv
// -----------------------------------------------------------------------------
// stoch_to_bin
//   Converts a unipolar stochastic bitstream to a binary value by counting the
//   ones over a window of N = 2^(k+1) clock cycles. The count is scaled to
//   WIDTH bits (count << (WIDTH-1-k)) and saturates to all-ones when every
//   sample in the window was 1. The result is held with a valid/ready
//   handshake. A new window may start in the same cycle the result is taken.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request a new conversion window (IDLE, or HOLD on handshake)
//   win_sel    in   window exponent k, latched on the start edge
//   clr        in   synchronous abort to IDLE (highest priority)
//   bit_in     in   stochastic bitstream sampled during ACCUM
//   out_ready  in   downstream accepts value
//   value      out  converted binary result
//   out_valid  out  value is valid and held
//   busy       out  high while a window is accumulating
// -----------------------------------------------------------------------------
module stoch_to_bin #(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] win_sel,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] value,
  output logic             out_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] k_q, k_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   cyc_q, cyc_d;
  logic [WIDTH-1:0] value_q, value_d;

  logic             hs;
  logic             load;
  logic             last_samp;
  logic [WIDTH:0]   cnt_inc;

  // Window length N = 2^(k+1); needs WIDTH+1 bits when k = WIDTH-1.
  function automatic logic [WIDTH:0] win_len(input logic [SEL_W-1:0] k);
    logic [WIDTH:0] one_w;
    one_w   = (WIDTH+1)'(1);
    win_len = (one_w << k) << 1;
  endfunction

  function automatic logic [SEL_W-1:0] clamp_k(input logic [SEL_W-1:0] ws);
    if ({1'b0, ws} >= (SEL_W+1)'(WIDTH)) clamp_k = SEL_W'(WIDTH-1);
    else                                 clamp_k = ws;
  endfunction

  // Scale count to WIDTH bits; an all-ones window would equal 2^WIDTH, so
  // it saturates. Any other count stays below 2^WIDTH after the shift.
  function automatic logic [WIDTH-1:0] sat_scale(input logic [WIDTH:0]   cnt,
                                                 input logic [SEL_W-1:0] k);
    logic [SEL_W-1:0] shamt;
    shamt = SEL_W'(WIDTH-1) - k;
    if (cnt == win_len(k)) sat_scale = {WIDTH{1'b1}};
    else                   sat_scale = WIDTH'(cnt << shamt);
  endfunction

  assign hs        = (state_q == S_HOLD) && out_ready;
  assign load      = start && ((state_q == S_IDLE) || hs);
  assign last_samp = (cyc_q == (win_len(k_q) - (WIDTH+1)'(1)));
  assign cnt_inc   = cnt_q + {{WIDTH{1'b0}}, bit_in};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clr overrides start and the handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: if (last_samp) state_d = S_HOLD;
      S_HOLD:  if (hs) state_d = start ? S_ACCUM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) state_d = S_IDLE;
  end

  // Outputs
  always_comb begin
    busy      = (state_q == S_ACCUM);
    out_valid = (state_q == S_HOLD);
    value     = value_q;
  end

  // Datapath next-state
  always_comb begin
    k_d     = k_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    value_d = value_q;
    if (clr) begin
      cnt_d = '0;
      cyc_d = '0;
    end else if (load) begin
      k_d   = clamp_k(win_sel);
      cnt_d = '0;
      cyc_d = '0;
    end else if (state_q == S_ACCUM) begin
      cnt_d = cnt_inc;
      cyc_d = cyc_q + (WIDTH+1)'(1);
      if (last_samp) value_d = sat_scale(cnt_inc, k_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      value_q <= '0;
    end else begin
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      value_q <= value_d;
    end
  end

endmodule
